mem_dump_reader: RTL and testbench

- Read-back engine for the pipelined MIPS32 data memory. It is the reader for the data the CPU writes with SW.
- Once the CPU has halted (HLT retired), it walks a contiguous word range of DataMem through a synchronous read port.
- It streams each word with its address over a valid/ready interface to the bench, debug UART or scoreboard.
- It replaces hierarchical peeks such as DataMem[198] for checking program results.

---
 rtl/mem_dump_reader.sv | 146 ++++++++++++++
 tb/tb_mem_dump_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Read-back engine for the MIPS32 DataMem: once the CPU has halted, walks a word range
// through the synchronous read port and streams {addr, data} over valid/ready.
module mem_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    WAIT_HALT,
    CAPTURE,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          addr_d = base_addr;
          rem_d  = count;
          busy_d = 1'b1;
          // Empty dump: a one-cycle busy/done pair via ZERO, no reads.
          if (count == '0) begin
            done_d  = 1'b1;
            state_d = ZERO;
          end else begin
            state_d = WAIT_HALT;
          end
        end
      end
      ZERO: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      WAIT_HALT: begin
        if (halted) begin
          rd_en   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        data_d  = mem_rdata;
        oaddr_d = addr_q;
        valid_d = 1'b1;
        last_d  = (rem_q == CNT_W'(1));
        state_d = SEND;
      end
      SEND: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          rem_d   = rem_q - CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // Next read overlaps the handshake so a word leaves every 2 cycles.
            rd_en   = 1'b1;
            rd_addr = addr_q + ADDR_W'(1);
            state_d = CAPTURE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Strobes are masked by reset so nothing reaches memory or the consumer during reset.
  assign mem_rd_en  = rd_en & ~reset;
  assign mem_addr   = rd_addr;
  assign dout_valid = valid_q;
  assign dout_data  = data_q;
  assign dout_addr  = oaddr_q;
  assign dout_last  = last_q & ~reset;
  assign busy       = busy_q;
  assign done       = done_q & ~reset;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: table of dumps plus hand-written corner sequences,
// with a scoreboard of expected {addr, data, last} words.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        halted;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic [9:0]  dout_addr;
  logic        dout_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mem_dump_reader #(.ADDR_W(10), .DATA_W(32), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .halted(halted), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_addr(dout_addr), .dout_last(dout_last), .busy(busy), .done(done)
  );

  logic [31:0] mem [1024];

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] cnt;
    int          halt_dly;
    logic        rnd_ready;
    int          exp_reads;
    logic [9:0]  exp_last_addr;
  } vec_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int rd_cnt = 0, hs_cnt = 0, done_cnt = 0, cyc = 0, last_hs_cyc = -100;
  logic [9:0] last_hs_addr = '0;
  logic zero_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Sample the current cycle shortly after inputs settle, then advance to edge+1.
  task automatic tick();
    exp_t e;
    #1;
    if (mem_rd_en) rd_cnt++;
    if (done) begin
      done_cnt++;
      if (!zero_mode) chk("done_after_last", 64'(cyc - last_hs_cyc), 64'd1);
    end
    if (dout_valid && dout_ready) begin
      hs_cnt++;
      last_hs_cyc  = cyc;
      last_hs_addr = dout_addr;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_word actual=%0h required=none", dout_addr);
      end else begin
        e = exp_q.pop_front();
        chk("word_addr", 64'(dout_addr), 64'(e.addr));
        chk("word_data", 64'(dout_data), 64'(e.data));
        chk("word_last", 64'(dout_last), 64'(e.last));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [9:0] b, input logic [10:0] c);
    logic [9:0] a;
    for (int k = 0; k < int'(c); k++) begin
      a = b + 10'(k);
      exp_q.push_back('{addr: a, data: mem[a], last: (k == int'(c) - 1)});
    end
  endtask

  task automatic do_start(input logic [9:0] b, input logic [10:0] c, input logic expect_taken);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    if (expect_taken) push_dump(b, c);
    last_hs_cyc = -100;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic rnd, input string nm);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      if (rnd) dout_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk(nm, 64'(done_cnt - d0), 64'd1);
    dout_ready = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    while (!dout_valid && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 64'(dout_valid), 64'd1);
  endtask

  initial begin
    vec_t vecs[7];
    int rd0, hs0;
    logic [31:0] hd;
    logic [9:0]  ha;
    logic        stable;
    int          n;

    for (int i = 0; i < 1024; i++) mem[i] = {16'(i), ~16'(i)};
    mem[198] = 32'd40320;
    mem[200] = 32'd8;

    reset = 1'b1; start = 1'b0; halted = 1'b0; dout_ready = 1'b0;
    base_addr = '0; count = '0;
    tick();
    tick();
    chk("reset_outputs", 64'({mem_rd_en, mem_addr, dout_valid, dout_data, dout_addr,
                              dout_last, busy, done}), 64'd0);
    reset = 1'b0;
    tick();

    vecs[0] = '{10'd198,  11'd3,    0, 1'b0, 3,    10'd200};
    vecs[1] = '{10'd1023, 11'd2,    0, 1'b0, 2,    10'd0};
    vecs[2] = '{10'd5,    11'd1,    3, 1'b0, 1,    10'd5};
    vecs[3] = '{10'd0,    11'd0,    0, 1'b0, 0,    10'd0};
    vecs[4] = '{10'd1020, 11'd6,    1, 1'b1, 6,    10'd1};
    vecs[5] = '{10'd700,  11'd5,    2, 1'b1, 5,    10'd704};
    vecs[6] = '{10'd1000, 11'd1030, 0, 1'b0, 1030, 10'd1005};

    for (int v = 0; v < 7; v++) begin
      halted     = (vecs[v].halt_dly == 0);
      dout_ready = 1'b1;
      zero_mode  = (vecs[v].cnt == 0);
      rd0 = rd_cnt;
      hs0 = hs_cnt;
      do_start(vecs[v].base, vecs[v].cnt, 1'b1);
      for (int d = 0; d < vecs[v].halt_dly; d++) tick();
      halted = 1'b1;
      wait_done(int'(vecs[v].cnt) * 8 + 40, vecs[v].rnd_ready, "vec_done");
      chk("vec_reads", 64'(rd_cnt - rd0), 64'(vecs[v].exp_reads));
      chk("vec_words", 64'(hs_cnt - hs0), 64'(vecs[v].cnt));
      if (vecs[v].cnt != 0) chk("vec_last_addr", 64'(last_hs_addr), 64'(vecs[v].exp_last_addr));
      chk("vec_busy_end", 64'(busy), 64'd0);
      chk("vec_queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      zero_mode = 1'b0;
      tick();
    end

    // count==0: done and busy for exactly the cycle after start
    zero_mode = 1'b1;
    hs0 = hs_cnt;
    do_start(10'd77, 11'd0, 1'b1);
    chk("zero_done_pulse", 64'({done, busy}), 64'b11);
    tick();
    chk("zero_after", 64'({done, busy, dout_valid}), 64'd0);
    chk("zero_no_words", 64'(hs_cnt - hs0), 64'd0);
    zero_mode = 1'b0;

    // wait for halt, then first valid 2 cycles after halted seen
    halted = 1'b0;
    rd0 = rd_cnt;
    do_start(10'd40, 11'd2, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("halt_no_reads", 64'(rd_cnt - rd0), 64'd0);
    chk("halt_busy", 64'(busy), 64'd1);
    halted = 1'b1;
    n = 0;
    while (!dout_valid && n < 10) begin
      tick();
      n++;
    end
    chk("halt_latency", 64'(n), 64'd2);
    wait_done(40, 1'b0, "halt_done");

    // backpressure: outputs frozen, no second read
    dout_ready = 1'b0;
    rd0 = rd_cnt;
    do_start(10'd10, 11'd2, 1'b1);
    wait_valid(10, "bp_valid");
    hd = dout_data;
    ha = dout_addr;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!dout_valid || dout_data !== hd || dout_addr !== ha) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    chk("bp_one_read", 64'(rd_cnt - rd0), 64'd1);
    dout_ready = 1'b1;
    wait_done(40, 1'b0, "bp_done");

    // reset while in SEND
    dout_ready = 1'b0;
    do_start(10'd300, 11'd4, 1'b1);
    wait_valid(10, "rst_valid");
    n = done_cnt;
    reset = 1'b1;
    tick();
    chk("rst_outputs", 64'({mem_rd_en, mem_addr, dout_valid, dout_data, dout_addr,
                            dout_last, busy, done}), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    dout_ready = 1'b1;
    tick();
    chk("rst_no_done", 64'(done_cnt - n), 64'd0);
    hs0 = hs_cnt;
    do_start(10'd301, 11'd2, 1'b1);
    wait_done(40, 1'b0, "rst_fresh_done");
    chk("rst_fresh_words", 64'(hs_cnt - hs0), 64'd2);

    // start while busy is ignored
    hs0 = hs_cnt;
    do_start(10'd600, 11'd3, 1'b1);
    tick();
    do_start(10'd500, 11'd5, 1'b0);
    wait_done(60, 1'b0, "busy_done");
    chk("busy_words", 64'(hs_cnt - hs0), 64'd3);
    chk("busy_last_addr", 64'(last_hs_addr), 64'd602);
    for (int i = 0; i < 5; i++) tick();
    chk("busy_idle", 64'({busy, dout_valid}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
